// File: rtl/tpu_cmd_sequencer.sv
// Command sequencer for the TPU: buffers compact commands in a FIFO and expands
// each into UB read / weight switch / VPU control timing with drain waits.
module tpu_cmd_sequencer #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int PIPE_LAT             = 4,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [1:0]  cmd_op_in,
  input  logic [15:0] cmd_addr_in,
  input  logic [15:0] cmd_count_in,
  input  logic [3:0]  cmd_pathway_in,
  input  logic [1:0]  cmd_mode_in,
  output logic        ub_rd_start_out,
  output logic [8:0]  ub_ptr_select_out,
  output logic [15:0] ub_rd_addr_out,
  output logic [15:0] ub_rd_col_size_out,
  output logic        sys_switch_out,
  output logic [3:0]  vpu_data_pathway_out,
  output logic [1:0]  sys_mode_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        err_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OP_LOAD_W = 2'd0, OP_STREAM_X = 2'd1, OP_WAIT = 2'd2, OP_SWITCH = 2'd3;
  localparam logic [17:0] STREAM_DRAIN = 18'(2 * SYSTOLIC_ARRAY_WIDTH + PIPE_LAT);

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] count;
    logic [3:0]  pathway;
    logic [1:0]  mode;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SWITCH, S_DONE} state_t;

  cmd_t          fifo_mem [FIFO_DEPTH];
  cmd_t          cmd_in, head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fill;
  logic          full, empty, push, pop;

  state_t        state, state_d;
  logic [1:0]    cur_op;
  logic [15:0]   cur_addr, cur_count;
  logic [17:0]   wait_cnt, wait_cnt_d, w_val;
  logic          is_rd, illegal, issue_rd;
  logic [3:0]    pathway_q;
  logic [1:0]    mode_q;
  logic          err_q;

  assign cmd_in        = '{cmd_op_in, cmd_addr_in, cmd_count_in, cmd_pathway_in, cmd_mode_in};
  assign head          = fifo_mem[rd_ptr];
  assign full          = (fill == (PW+1)'(FIFO_DEPTH));
  assign empty         = (fill == '0);
  // Ready is withheld during reset and flush so a coincident push is dropped.
  assign cmd_ready_out = !full && !rst && !flush_in;
  assign push          = cmd_valid_in && cmd_ready_out;
  assign pop           = (state == S_IDLE) && !empty && !flush_in;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign is_rd   = (cur_op == OP_LOAD_W) || (cur_op == OP_STREAM_X);
  assign illegal = is_rd && (cur_count == '0);

  // Wait length at 18 bits so count=0xFFFF plus drain cannot wrap.
  always_comb begin
    w_val = '0;
    case (cur_op)
      OP_LOAD_W:   w_val = {2'b00, cur_count} + 18'd1;
      OP_STREAM_X: w_val = {2'b00, cur_count} + STREAM_DRAIN;
      OP_WAIT:     w_val = {2'b00, cur_count};
      default:     w_val = '0;
    endcase
  end

  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    case (state)
      S_IDLE:  if (pop) state_d = S_ISSUE;
      S_ISSUE: begin
        if (illegal) state_d = S_DONE;
        else if (w_val != '0) begin
          state_d    = S_WAIT;
          wait_cnt_d = w_val;
        end else if (cur_op == OP_SWITCH || cur_op == OP_LOAD_W) state_d = S_SWITCH;
        else state_d = S_DONE;
      end
      S_WAIT: begin
        if (wait_cnt <= 18'd1) begin
          wait_cnt_d = '0;
          state_d    = (cur_op == OP_LOAD_W) ? S_SWITCH : S_DONE;
        end else wait_cnt_d = wait_cnt - 18'd1;
      end
      S_SWITCH: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (flush_in) begin
      state_d    = S_IDLE;
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      cur_op    <= '0;
      cur_addr  <= '0;
      cur_count <= '0;
      pathway_q <= '0;
      mode_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      if (pop) begin
        cur_op    <= head.op;
        cur_addr  <= head.addr;
        cur_count <= head.count;
        // Sticky VPU controls change at the pop edge so they are live in ISSUE.
        if (head.op == OP_STREAM_X && head.count != '0) begin
          pathway_q <= head.pathway;
          mode_q    <= head.mode;
        end
      end
      if (state == S_ISSUE && illegal && !flush_in) err_q <= 1'b1;
    end
  end

  assign issue_rd             = (state == S_ISSUE) && is_rd && !illegal;
  assign ub_rd_start_out      = issue_rd;
  assign ub_ptr_select_out    = {8'b0, issue_rd && (cur_op == OP_LOAD_W)};
  assign ub_rd_addr_out       = issue_rd ? cur_addr : '0;
  assign ub_rd_col_size_out   = issue_rd ? cur_count : '0;
  assign sys_switch_out       = (state == S_SWITCH);
  assign done_out             = (state == S_DONE);
  assign busy_out             = (state != S_IDLE) || !empty;
  assign vpu_data_pathway_out = pathway_q;
  assign sys_mode_out         = mode_q;
  assign err_out              = err_q;
endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
// Directed bench for tpu_cmd_sequencer: a timing model queues expected
// start/switch/done events per command, a negedge monitor pops and compares.
module tb_tpu_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst, flush_in, cmd_valid_in, cmd_ready_out;
  logic [1:0]  cmd_op_in, sys_mode_out, cmd_mode_in;
  logic [15:0] cmd_addr_in, cmd_count_in, ub_rd_addr_out, ub_rd_col_size_out;
  logic [3:0]  cmd_pathway_in, vpu_data_pathway_out;
  logic [8:0]  ub_ptr_select_out;
  logic        ub_rd_start_out, sys_switch_out, busy_out, done_out, err_out;

  always #5 clk = ~clk;

  tpu_cmd_sequencer #(.SYSTOLIC_ARRAY_WIDTH(2), .PIPE_LAT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush_in(flush_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_op_in(cmd_op_in), .cmd_addr_in(cmd_addr_in), .cmd_count_in(cmd_count_in),
    .cmd_pathway_in(cmd_pathway_in), .cmd_mode_in(cmd_mode_in),
    .ub_rd_start_out(ub_rd_start_out), .ub_ptr_select_out(ub_ptr_select_out),
    .ub_rd_addr_out(ub_rd_addr_out), .ub_rd_col_size_out(ub_rd_col_size_out),
    .sys_switch_out(sys_switch_out), .vpu_data_pathway_out(vpu_data_pathway_out),
    .sys_mode_out(sys_mode_out), .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
  );

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] col;
    logic [8:0]  ptr;
    logic [3:0]  pw;
    logic [1:0]  md;
  } start_t;
  typedef struct {
    int   cyc;
    logic err;
  } done_t;

  start_t start_q[$];
  done_t  done_q[$];
  int     sw_q[$];

  int   cyc = 0;
  int   total = 0, passes = 0, fails = 0;
  int   free_cyc = 0;
  logic err_m = 1'b0;
  logic [3:0] pw_m = '0;
  logic [1:0] md_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    start_t s;
    done_t  d;
    int     sc;
    if (rst === 1'b0) begin
      if (ub_rd_start_out === 1'b1) begin
        chk("start_expected", start_q.size() > 0, 1);
        if (start_q.size() > 0) begin
          s = start_q.pop_front();
          chk("start_cyc", cyc, s.cyc);
          chk("start_addr", ub_rd_addr_out, s.addr);
          chk("start_col", ub_rd_col_size_out, s.col);
          chk("start_ptr", ub_ptr_select_out, s.ptr);
          chk("start_pathway", vpu_data_pathway_out, s.pw);
          chk("start_mode", sys_mode_out, s.md);
        end
      end
      if (sys_switch_out === 1'b1) begin
        chk("switch_expected", sw_q.size() > 0, 1);
        if (sw_q.size() > 0) begin
          sc = sw_q.pop_front();
          chk("switch_cyc", cyc, sc);
        end
      end
      if (done_out === 1'b1) begin
        chk("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          d = done_q.pop_front();
          chk("done_cyc", cyc, d.cyc);
          chk("done_err", err_out, d.err);
        end
      end
    end
  end

  // Called at a negedge; holds the command until accepted, then models its timeline.
  task automatic push_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] cnt,
                          input logic [3:0] pw, input logic [1:0] md, output int acc_cyc);
    bit     acc = 1'b0;
    int     pop_c, iss, w, dn;
    start_t s;
    done_t  d;
    cmd_op_in = op; cmd_addr_in = addr; cmd_count_in = cnt;
    cmd_pathway_in = pw; cmd_mode_in = md; cmd_valid_in = 1'b1;
    for (int i = 0; i < 400; i++) begin
      #1 acc = cmd_ready_out;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    chk("push_accepted", acc, 1);
    #1 acc_cyc = cyc;
    pop_c = (acc_cyc > free_cyc) ? acc_cyc : free_cyc;
    iss = pop_c + 1;
    case (op)
      2'd0:    w = int'(cnt) + 1;
      2'd1:    w = int'(cnt) + 8;
      2'd2:    w = int'(cnt);
      default: w = 0;
    endcase
    if (op <= 2'd1 && cnt == 16'd0) begin
      err_m = 1'b1;
      dn = iss + 1;
    end else begin
      if (op == 2'd1) begin pw_m = pw; md_m = md; end
      if (op <= 2'd1) begin
        s.cyc = iss; s.addr = addr; s.col = cnt; s.ptr = {8'b0, op == 2'd0};
        s.pw = pw_m; s.md = md_m;
        start_q.push_back(s);
      end
      if (op == 2'd0 || op == 2'd3) begin
        sw_q.push_back(iss + w + 1);
        dn = iss + w + 2;
      end else dn = iss + w + 1;
    end
    d.cyc = dn; d.err = err_m;
    done_q.push_back(d);
    free_cyc = dn + 1;
    @(negedge clk);
    cmd_valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((start_q.size() != 0 || sw_q.size() != 0 || done_q.size() != 0 || busy_out !== 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < 2000, 1);
    @(negedge clk);
  endtask

  task automatic forget_pending();
    start_q.delete(); sw_q.delete(); done_q.delete();
    free_cyc = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a5, a6, t;
    rst = 1'b1; flush_in = 1'b0; cmd_valid_in = 1'b0;
    cmd_op_in = '0; cmd_addr_in = '0; cmd_count_in = '0; cmd_pathway_in = '0; cmd_mode_in = '0;
    @(negedge clk);
    #1 chk("ready_in_reset", cmd_ready_out, 0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ub_rd_start_out, ub_ptr_select_out, ub_rd_addr_out, ub_rd_col_size_out,
        sys_switch_out, vpu_data_pathway_out, sys_mode_out, busy_out, done_out, err_out, cmd_ready_out}, 0);
    rst = 1'b0;
    #1 chk("ready_after_reset", cmd_ready_out, 1);
    @(negedge clk);

    // LOAD_W: start/ptr=1 in ISSUE, switch after W=count+1 wait cycles
    push_cmd(2'd0, 16'h0010, 16'd2, 4'h0, 2'd0, t);
    drain();
    // STREAM_X: W = count + 2N + PIPE_LAT, sticky pathway/mode
    push_cmd(2'd1, 16'h0040, 16'd3, 4'hC, 2'd1, t);
    drain();
    chk("pathway_held", vpu_data_pathway_out, 4'hC);
    chk("mode_held", sys_mode_out, 2'd1);
    // SWITCH command and minimum legal LOAD_W
    push_cmd(2'd3, 16'h0000, 16'd7, 4'h0, 2'd0, t);
    push_cmd(2'd0, 16'hFFFF, 16'd1, 4'h0, 2'd0, t);
    drain();

    // FIFO back-pressure with six long WAITs
    push_cmd(2'd2, 16'h0, 16'd100, 4'h0, 2'd0, a1);
    push_cmd(2'd2, 16'h0, 16'd100, 4'h0, 2'd0, t);
    push_cmd(2'd2, 16'h0, 16'd100, 4'h0, 2'd0, t);
    push_cmd(2'd2, 16'h0, 16'd100, 4'h0, 2'd0, t);
    push_cmd(2'd2, 16'h0, 16'd100, 4'h0, 2'd0, a5);
    chk("fifth_push_cyc", a5 - a1, 4);
    #1 chk("ready_when_full", cmd_ready_out, 0);
    chk("busy_when_full", busy_out, 1);
    push_cmd(2'd2, 16'h0, 16'd100, 4'h0, 2'd0, a6);
    chk("sixth_push_cyc", a6 - a1, 105);
    drain();

    // Illegal STREAM_X count 0, then a legal LOAD_W
    chk("err_before_illegal", err_out, 0);
    push_cmd(2'd1, 16'h0050, 16'd0, 4'hF, 2'd3, t);
    push_cmd(2'd0, 16'h0022, 16'd1, 4'h0, 2'd0, t);
    drain();
    chk("err_sticky", err_out, 1);
    chk("pathway_not_updated", vpu_data_pathway_out, 4'hC);
    chk("mode_not_updated", sys_mode_out, 2'd1);

    // Flush in the WAIT of a STREAM_X with two commands queued and a coincident push
    push_cmd(2'd1, 16'h0080, 16'd50, 4'h5, 2'd2, t);
    push_cmd(2'd2, 16'h0, 16'd5, 4'h0, 2'd0, t);
    push_cmd(2'd2, 16'h0, 16'd5, 4'h0, 2'd0, t);
    repeat (5) @(negedge clk);
    flush_in = 1'b1;
    cmd_op_in = 2'd2; cmd_count_in = 16'd1; cmd_valid_in = 1'b1;
    #1 chk("ready_during_flush", cmd_ready_out, 0);
    @(negedge clk);
    flush_in = 1'b0; cmd_valid_in = 1'b0;
    forget_pending();
    #1 chk("busy_after_flush", busy_out, 0);
    chk("ready_after_flush", cmd_ready_out, 1);
    chk("pathway_after_flush", vpu_data_pathway_out, 4'h5);
    chk("mode_after_flush", sys_mode_out, 2'd2);
    chk("err_after_flush", err_out, 1);
    repeat (120) @(negedge clk);
    chk("idle_after_flush", busy_out, 0);

    // Reset in the WAIT of a LOAD_W
    push_cmd(2'd0, 16'h0030, 16'd20, 4'h0, 2'd0, t);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("outputs_in_reset", {ub_rd_start_out, ub_ptr_select_out, ub_rd_addr_out, ub_rd_col_size_out,
        sys_switch_out, vpu_data_pathway_out, sys_mode_out, busy_out, done_out, err_out, cmd_ready_out}, 0);
    forget_pending();
    err_m = 1'b0; pw_m = '0; md_m = '0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", cmd_ready_out, 1);
    repeat (30) @(negedge clk);
    chk("idle_after_rst", busy_out, 0);
    push_cmd(2'd2, 16'h0, 16'd0, 4'h0, 2'd0, t);
    drain();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
